// File: rtl/jtag_tap_if.sv
// Pin-level bundle between the TAP controller and the test pins / test data registers.
// The slave side is the TAP itself; the master side drives TMS/TDI and the DR serial returns.
interface jtag_tap_if;
  logic tms_i;
  logic tdi_i;
  logic bs_chain_so_i;
  logic mbist_so_i;
  logic debug_so_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic tlr_o;
  logic capture_dr_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic extest_select_o;
  logic sample_preload_select_o;
  logic mbist_select_o;
  logic debug_select_o;

  modport master (
    output tms_i, tdi_i, bs_chain_so_i, mbist_so_i, debug_so_i,
    input  tdo_o, tdo_oe_o, tlr_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
    input  extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o
  );

  modport slave (
    input  tms_i, tdi_i, bs_chain_so_i, mbist_so_i, debug_so_i,
    output tdo_o, tdo_oe_o, tlr_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
    output extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, 4-bit IR, BYPASS and IDCODE registers,
// DR control strobes, one-hot instruction selects and a negedge-registered TDO mux.
module jtag_tap_ctrl #(
  parameter int                IR_LEN     = 4,
  parameter logic [31:0]       IDCODE_VAL = 32'h0180_0B4D,
  parameter logic [IR_LEN-1:0] OP_EXTEST  = 4'b0000,
  parameter logic [IR_LEN-1:0] OP_SAMPLE  = 4'b0001,
  parameter logic [IR_LEN-1:0] OP_IDCODE  = 4'b0010,
  parameter logic [IR_LEN-1:0] OP_MBIST   = 4'b1000,
  parameter logic [IR_LEN-1:0] OP_DEBUG   = 4'b1001,
  parameter logic [IR_LEN-1:0] OP_BYPASS  = 4'b1111
) (
  input logic       tck_i,
  input logic       test_logic_reset_i,
  jtag_tap_if.slave tap
);

  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(4'b0101);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e        state_q;
  logic [IR_LEN-1:0] ir_q, ir_d;
  logic [IR_LEN-1:0] ir_shift_q, ir_shift_d;
  logic              bypass_q, bypass_d;
  logic [31:0]       idcode_q, idcode_d;
  logic              tdo_q, tdo_d;
  logic              tdo_oe_q, tdo_oe_d;

  logic sel_extest, sel_sample, sel_idcode, sel_mbist, sel_debug, sel_bypass;

  // Standard 1149.1 state graph, advanced on every rising TCK edge.
  always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:     state_q <= tap.tms_i ? TLR    : RTI;
        RTI:     state_q <= tap.tms_i ? SEL_DR : RTI;
        SEL_DR:  state_q <= tap.tms_i ? SEL_IR : CAP_DR;
        CAP_DR:  state_q <= tap.tms_i ? EX1_DR : SH_DR;
        SH_DR:   state_q <= tap.tms_i ? EX1_DR : SH_DR;
        EX1_DR:  state_q <= tap.tms_i ? UPD_DR : PA_DR;
        PA_DR:   state_q <= tap.tms_i ? EX2_DR : PA_DR;
        EX2_DR:  state_q <= tap.tms_i ? UPD_DR : SH_DR;
        UPD_DR:  state_q <= tap.tms_i ? SEL_DR : RTI;
        SEL_IR:  state_q <= tap.tms_i ? TLR    : CAP_IR;
        CAP_IR:  state_q <= tap.tms_i ? EX1_IR : SH_IR;
        SH_IR:   state_q <= tap.tms_i ? EX1_IR : SH_IR;
        EX1_IR:  state_q <= tap.tms_i ? UPD_IR : PA_IR;
        PA_IR:   state_q <= tap.tms_i ? EX2_IR : PA_IR;
        EX2_IR:  state_q <= tap.tms_i ? UPD_IR : SH_IR;
        UPD_IR:  state_q <= tap.tms_i ? SEL_DR : RTI;
        default: state_q <= TLR;
      endcase
    end
  end

  assign sel_extest = (ir_q == OP_EXTEST);
  assign sel_sample = (ir_q == OP_SAMPLE);
  assign sel_idcode = (ir_q == OP_IDCODE);
  assign sel_mbist  = (ir_q == OP_MBIST);
  assign sel_debug  = (ir_q == OP_DEBUG);
  // OP_BYPASS and every unlisted opcode fall through to the bypass bit.
  assign sel_bypass = !(sel_extest || sel_sample || sel_idcode || sel_mbist || sel_debug);

  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    case (state_q)
      TLR:    ir_d       = OP_IDCODE;
      CAP_IR: ir_shift_d = IR_CAPTURE;
      SH_IR:  ir_shift_d = {tap.tdi_i, ir_shift_q[IR_LEN-1:1]};
      UPD_IR: ir_d       = ir_shift_q;
      CAP_DR: begin
        if (sel_idcode) idcode_d = IDCODE_VAL;
        if (sel_bypass) bypass_d = 1'b0;
      end
      SH_DR: begin
        if (sel_idcode) idcode_d = {tap.tdi_i, idcode_q[31:1]};
        if (sel_bypass) bypass_d = tap.tdi_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      ir_q       <= OP_IDCODE;
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
      idcode_q   <= IDCODE_VAL;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
    end
  end

  // TDO source selection; the register on the falling edge gives the far end a half-cycle of setup.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_oe_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_oe_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_oe_d = 1'b1;
      if (sel_extest || sel_sample) tdo_d = tap.bs_chain_so_i;
      else if (sel_mbist)           tdo_d = tap.mbist_so_i;
      else if (sel_debug)           tdo_d = tap.debug_so_i;
      else if (sel_idcode)          tdo_d = idcode_q[0];
      else                          tdo_d = bypass_q;
    end
  end

  always_ff @(negedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tap.tdo_o                   = tdo_q;
  assign tap.tdo_oe_o                = tdo_oe_q;
  assign tap.tlr_o                   = (state_q == TLR);
  assign tap.capture_dr_o            = (state_q == CAP_DR);
  assign tap.shift_dr_o              = (state_q == SH_DR);
  assign tap.pause_dr_o              = (state_q == PA_DR);
  assign tap.update_dr_o             = (state_q == UPD_DR);
  assign tap.extest_select_o         = sel_extest;
  assign tap.sample_preload_select_o = sel_sample;
  assign tap.mbist_select_o          = sel_mbist;
  assign tap.debug_select_o          = sel_debug;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed TAP walks plus random TMS/TDI traffic, each cycle
// compared with a state-name/queue reference model of the TAP.
module tb_jtag_tap_ctrl;
  localparam logic [31:0] IDCODE_VAL = 32'h0180_0B4D;

  logic tck  = 1'b0;
  logic trst = 1'b0;
  jtag_tap_if tapIf();

  jtag_tap_ctrl #(.IDCODE_VAL(IDCODE_VAL)) dut (
    .tck_i             (tck),
    .test_logic_reset_i(trst),
    .tap               (tapIf)
  );

  always #5 tck = ~tck;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: states are names, shift registers are LSB-first bit queues.
  string nxt0[string];
  string nxt1[string];
  string mState;
  int    mIr;
  bit    irQ[$];
  bit    idQ[$];
  bit    mBypass;
  logic  lastTdo;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function void initTables();
    nxt0["TLR"] = "RTI";       nxt1["TLR"] = "TLR";
    nxt0["RTI"] = "RTI";       nxt1["RTI"] = "SEL_DR";
    nxt0["SEL_DR"] = "CAP_DR"; nxt1["SEL_DR"] = "SEL_IR";
    nxt0["CAP_DR"] = "SH_DR";  nxt1["CAP_DR"] = "EX1_DR";
    nxt0["SH_DR"] = "SH_DR";   nxt1["SH_DR"] = "EX1_DR";
    nxt0["EX1_DR"] = "PA_DR";  nxt1["EX1_DR"] = "UPD_DR";
    nxt0["PA_DR"] = "PA_DR";   nxt1["PA_DR"] = "EX2_DR";
    nxt0["EX2_DR"] = "SH_DR";  nxt1["EX2_DR"] = "UPD_DR";
    nxt0["UPD_DR"] = "RTI";    nxt1["UPD_DR"] = "SEL_DR";
    nxt0["SEL_IR"] = "CAP_IR"; nxt1["SEL_IR"] = "TLR";
    nxt0["CAP_IR"] = "SH_IR";  nxt1["CAP_IR"] = "EX1_IR";
    nxt0["SH_IR"] = "SH_IR";   nxt1["SH_IR"] = "EX1_IR";
    nxt0["EX1_IR"] = "PA_IR";  nxt1["EX1_IR"] = "UPD_IR";
    nxt0["PA_IR"] = "PA_IR";   nxt1["PA_IR"] = "EX2_IR";
    nxt0["EX2_IR"] = "SH_IR";  nxt1["EX2_IR"] = "UPD_IR";
    nxt0["UPD_IR"] = "RTI";    nxt1["UPD_IR"] = "SEL_DR";
  endfunction

  function void loadIdcode();
    logic [31:0] v;
    v = IDCODE_VAL;
    idQ.delete();
    for (int i = 0; i < 32; i++) idQ.push_back(v[i]);
  endfunction

  function void modelReset();
    mState = "TLR";
    mIr = 2;
    irQ.delete();
    for (int i = 0; i < 4; i++) irQ.push_back(1'b0);
    loadIdcode();
    mBypass = 1'b0;
  endfunction

  function bit isBypassOp(int ir);
    return !(ir == 0 || ir == 1 || ir == 2 || ir == 8 || ir == 9);
  endfunction

  function void modelClock(bit tms, bit tdi);
    if (mState == "TLR") begin
      mIr = 2;
    end else if (mState == "CAP_IR") begin
      irQ.delete();
      irQ.push_back(1'b1); irQ.push_back(1'b0); irQ.push_back(1'b1); irQ.push_back(1'b0);
    end else if (mState == "SH_IR") begin
      void'(irQ.pop_front());
      irQ.push_back(tdi);
    end else if (mState == "UPD_IR") begin
      mIr = 0;
      for (int i = 0; i < 4; i++) mIr += int'(irQ[i]) << i;
    end else if (mState == "CAP_DR") begin
      if (mIr == 2) loadIdcode();
      if (isBypassOp(mIr)) mBypass = 1'b0;
    end else if (mState == "SH_DR") begin
      if (mIr == 2) begin
        void'(idQ.pop_front());
        idQ.push_back(tdi);
      end
      if (isBypassOp(mIr)) mBypass = tdi;
    end
    mState = tms ? nxt1[mState] : nxt0[mState];
  endfunction

  function logic [4:0] expStrobes();
    return {mState == "TLR", mState == "CAP_DR", mState == "SH_DR",
            mState == "PA_DR", mState == "UPD_DR"};
  endfunction

  function logic [3:0] expSelects();
    return {mIr == 0, mIr == 1, mIr == 8, mIr == 9};
  endfunction

  function logic [4:0] dutStrobes();
    return {tapIf.tlr_o, tapIf.capture_dr_o, tapIf.shift_dr_o, tapIf.pause_dr_o, tapIf.update_dr_o};
  endfunction

  function logic [3:0] dutSelects();
    return {tapIf.extest_select_o, tapIf.sample_preload_select_o,
            tapIf.mbist_select_o, tapIf.debug_select_o};
  endfunction

  // One TCK cycle: drive inputs, check decodes after the rise, check TDO after the fall.
  task automatic applyStimulus(input bit tms, input bit tdi, input bit bs, input bit mb, input bit dbg);
    bit expTdo;
    bit expOe;
    tapIf.tms_i = tms;
    tapIf.tdi_i = tdi;
    tapIf.bs_chain_so_i = bs;
    tapIf.mbist_so_i = mb;
    tapIf.debug_so_i = dbg;
    @(posedge tck);
    #1;
    modelClock(tms, tdi);
    checkOutput("strobes", 32'(dutStrobes()), 32'(expStrobes()));
    checkOutput("selects", 32'(dutSelects()), 32'(expSelects()));
    @(negedge tck);
    #1;
    expTdo = 1'b0;
    expOe = 1'b0;
    if (mState == "SH_IR") begin
      expOe = 1'b1;
      expTdo = irQ[0];
    end else if (mState == "SH_DR") begin
      expOe = 1'b1;
      if (mIr == 0 || mIr == 1) expTdo = bs;
      else if (mIr == 8)        expTdo = mb;
      else if (mIr == 9)        expTdo = dbg;
      else if (mIr == 2)        expTdo = idQ[0];
      else                      expTdo = mBypass;
    end
    checkOutput("tdo", 32'(tapIf.tdo_o), 32'(expTdo));
    checkOutput("tdo_oe", 32'(tapIf.tdo_oe_o), 32'(expOe));
    lastTdo = tapIf.tdo_o;
  endtask

  task automatic step(input bit tms, input bit tdi);
    applyStimulus(tms, tdi, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic doReset();
    trst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_strobes", 32'(dutStrobes()), 32'(5'b10000));
    checkOutput("rst_selects", 32'(dutSelects()), 32'(4'b0000));
    checkOutput("rst_tdo", 32'(tapIf.tdo_o), 32'(1'b0));
    checkOutput("rst_tdo_oe", 32'(tapIf.tdo_oe_o), 32'(1'b0));
    #1;
    trst = 1'b0;
  endtask

  // Starts and ends in RTI; returns the four TDO bits seen while shifting the IR.
  task automatic loadIr(input logic [3:0] val, output logic [3:0] capBits);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    capBits[0] = lastTdo;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, val[i]);
      if (i < 3) capBits[i + 1] = lastTdo;
    end
    step(1, 0);
    step(0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] idBits;
    logic [3:0]  cap;
    logic [3:0]  obs;
    logic [3:0]  bypassOps [2];
    bypassOps[0] = 4'b1111;
    bypassOps[1] = 4'b0110;
    initTables();
    tapIf.tms_i = 1'b0;
    tapIf.tdi_i = 1'b0;
    tapIf.bs_chain_so_i = 1'b0;
    tapIf.mbist_so_i = 1'b0;
    tapIf.debug_so_i = 1'b0;
    #1;
    doReset();

    repeat (5) step(1, 0);
    checkOutput("tlr_after_tms5", 32'(tapIf.tlr_o), 32'(1'b1));
    checkOutput("sel_after_tms5", 32'(dutSelects()), 32'(4'b0000));
    step(0, 0);

    $display("[TB] IDCODE scan");
    step(1, 0);
    step(0, 0);
    step(0, 0);
    idBits[0] = lastTdo;
    for (int k = 1; k < 32; k++) begin
      step(0, 0);
      idBits[k] = lastTdo;
    end
    checkOutput("idcode_seq", idBits, IDCODE_VAL);
    step(1, 0);
    step(1, 0);
    step(0, 0);

    $display("[TB] EXTEST load");
    loadIr(4'b0000, cap);
    checkOutput("ir_capture", 32'(cap), 32'(4'b0101));
    checkOutput("extest_sel", 32'(tapIf.extest_select_o), 32'(1'b1));

    $display("[TB] BYPASS scans");
    for (int b = 0; b < 2; b++) begin
      loadIr(bypassOps[b], cap);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      obs[0] = lastTdo;
      step(0, 1); obs[1] = lastTdo;
      step(0, 0); obs[2] = lastTdo;
      step(0, 1); obs[3] = lastTdo;
      step(1, 1);
      checkOutput("bypass_delay", 32'(obs), 32'(4'b1010));
      step(1, 0);
      step(0, 0);
    end

    $display("[TB] DEBUG scan and pause");
    loadIr(4'b1001, cap);
    checkOutput("debug_sel", 32'(tapIf.debug_select_o), 32'(1'b1));
    step(1, 0);
    step(0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), k[0] ? 1'b0 : 1'b1);
      checkOutput("debug_follow", 32'(lastTdo), 32'(k[0] ? 1'b0 : 1'b1));
    end
    step(1, 0);
    repeat (3) begin
      step(0, 0);
      checkOutput("pause_dr", 32'(tapIf.pause_dr_o), 32'(1'b1));
      checkOutput("pause_oe", 32'(tapIf.tdo_oe_o), 32'(1'b0));
    end
    step(1, 0);
    step(0, 0);
    step(1, 0);
    step(1, 0);
    step(0, 0);

    $display("[TB] reset during IR shift");
    loadIr(4'b0000, cap);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    doReset();
    checkOutput("abort_extest", 32'(tapIf.extest_select_o), 32'(1'b0));
    checkOutput("abort_tlr", 32'(tapIf.tlr_o), 32'(1'b1));
    step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    checkOutput("abort_ir_idcode", 32'(lastTdo), 32'(IDCODE_VAL[0]));
    step(1, 0);
    step(1, 0);
    step(0, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      else applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
